// File: rtl/recv_word_buffer.sv
// recv_word_buffer: packs the UART receiver's byte stream into 32-bit
// big-endian words and queues them in a small first-word-fall-through FIFO.
// A word that completes while the FIFO is full is dropped and recorded in a
// sticky overflow flag; the byte stream is never stalled.
module recv_word_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Assembler state
  logic [1:0]              idx_q, idx_d;
  logic [23:0]             hold_q, hold_d;

  // FIFO state
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [31:0]             mem_q [DEPTH];

  logic                    push;
  logic                    push_ok;
  logic                    pop;
  logic                    full;
  logic [31:0]             push_word;

  assign full      = (count_q == FULL_COUNT);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (idx_q == 2'd3);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts it.
  assign push_ok   = push && (!full || pop);
  assign push_word = {hold_q, in_data};

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

  // Next-state for assembler, pointers, occupancy and overflow flag
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    idx_d      = idx_q;
    hold_d     = hold_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (in_valid) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    hold_d[23:16] = in_data;
        2'd1:    hold_d[15:8]  = in_data;
        2'd2:    hold_d[7:0]   = in_data;
        default: ;  // fourth byte goes straight into the pushed word
      endcase
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !push_ok) overflow_d = 1'b1;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;  // idle, or simultaneous push and pop
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      idx_q      <= '0;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage write port
  always_ff @(posedge CLK) begin
    // NOTE: the array is deliberately not reset; out_data is only meaningful
    // while out_valid is high, and that requires a prior write.
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

endmodule

// File: tb/tb_recv_word_buffer.sv
// Directed self-checking bench for recv_word_buffer. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_recv_word_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  count;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  recv_word_buffer #(.DEPTH_LOG2(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock cycle; returns at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge CLK);
  endtask

  task automatic push_word(input logic [31:0] w);
    step(1'b1, w[31:24], 1'b0);
    step(1'b1, w[23:16], 1'b0);
    step(1'b1, w[15:8],  1'b0);
    step(1'b1, w[7:0],   1'b0);
  endtask

  task automatic pulse_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] exp_word;

    RST = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Basic word assembly and single pop
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h34, 1'b0);
    step(1'b1, 8'h56, 1'b0);
    check("partial_no_valid", 32'(out_valid), 32'd0);
    step(1'b1, 8'h78, 1'b0);
    check("w1_valid", 32'(out_valid), 32'd1);
    check("w1_data",  out_data,       32'h12345678);
    check("w1_count", 32'(count),     32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("w1_pop_valid", 32'(out_valid), 32'd0);
    check("w1_pop_count", 32'(count),     32'd0);

    // Reset mid-word discards the partial bytes; reset acts asynchronously
    push_word(32'h11223344);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h66, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    check("pre_rst_count", 32'(count), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_count", 32'(count),     32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    step(1'b1, 8'hCC, 1'b0);
    check("post_rst_partial", 32'(out_valid), 32'd0);
    step(1'b1, 8'hDD, 1'b0);
    check("post_rst_data",  out_data,   32'hAABBCCDD);
    check("post_rst_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("post_rst_empty", 32'(count), 32'd0);

    // Fill to 16, overflow on the 17th, drain in order
    for (int n = 0; n < 16; n++) push_word(32'(n));
    check("fill_count",    32'(count),    32'd16);
    check("fill_overflow", 32'(overflow), 32'd0);
    check("fill_head",     out_data,      32'd0);
    push_word(32'h000000FF);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'd16);
    check("ovf_head",  out_data,      32'd0);
    // Partial word after overflow must start at byte 0 again
    for (int n = 0; n < 16; n++) begin
      check($sformatf("drain_%0d", n), out_data, 32'(n));
      step(1'b0, 8'h00, 1'b1);
    end
    check("drain_empty",    32'(out_valid), 32'd0);
    check("drain_count",    32'(count),     32'd0);
    check("drain_overflow", 32'(overflow),  32'd1);
    push_word(32'hCAFEF00D);
    check("after_ovf_align", out_data, 32'hCAFEF00D);
    step(1'b0, 8'h00, 1'b1);

    // Push while full with simultaneous pop
    pulse_reset();
    check("rst_clears_ovf", 32'(overflow), 32'd0);
    for (int n = 0; n < 16; n++) push_word(32'h100 + 32'(n));
    check("full2_count", 32'(count), 32'd16);
    step(1'b1, 8'hDE, 1'b0);
    step(1'b1, 8'hAD, 1'b0);
    step(1'b1, 8'hBE, 1'b0);
    step(1'b1, 8'hEF, 1'b1);
    check("pp_full_count",    32'(count),    32'd16);
    check("pp_full_overflow", 32'(overflow), 32'd0);
    check("pp_full_head",     out_data,      32'h101);
    for (int n = 1; n < 16; n++) begin
      check($sformatf("pp_drain_%0d", n), out_data, 32'h100 + 32'(n));
      step(1'b0, 8'h00, 1'b1);
    end
    check("pp_drain_last", out_data, 32'hDEADBEEF);
    step(1'b0, 8'h00, 1'b1);
    check("pp_drain_empty", 32'(count), 32'd0);

    // Back-to-back bytes with continuous ready; pointers wrap
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 8'(k), 1'b1);
      check("stream_cnt_le1", 32'(count <= 5'd1), 32'd1);
      if ((k % 4) == 3) begin
        exp_word = {8'(k - 3), 8'(k - 2), 8'(k - 1), 8'(k)};
        check($sformatf("stream_word_%0d", k / 4), out_data, exp_word);
        check("stream_valid", 32'(out_valid), 32'd1);
      end
    end
    step(1'b0, 8'h00, 1'b1);
    check("stream_empty", 32'(count), 32'd0);

    // Pops interleaved with a word being assembled
    push_word(32'h01020304);
    push_word(32'h05060708);
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("il_head_after_pop", out_data,   32'h05060708);
    check("il_count1",         32'(count), 32'd1);
    step(1'b1, 8'hB3, 1'b1);
    check("il_count0", 32'(count), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hB4, 1'b0);
    check("il_word",  out_data,   32'hB1B2B3B4);
    check("il_count", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
